// File: rtl/rca_share_arbiter_if.sv
// Bus between the two requesters, the shared-adder arbiter and the shared ripple-carry adder.
// Optional: define RCA_OVF_EN to add the registered two's-complement overflow flag ovf.
interface rca_share_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             c_in0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             c_in1;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_c_in;
    logic [WIDTH-1:0] add_sum;
    logic             add_c_out;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             done0;
    logic             done1;
    logic             busy;
`ifdef RCA_OVF_EN
    logic             ovf;
`endif

    // Environment side: requesters plus the adder's result outputs.
    modport master (
        output req0, a0, b0, c_in0, req1, a1, b1, c_in1, add_sum, add_c_out,
`ifdef RCA_OVF_EN
        input  ovf,
`endif
        input  add_a, add_b, add_c_in, sum, c_out, done0, done1, busy
    );

    modport slave (
        input  req0, a0, b0, c_in0, req1, a1, b1, c_in1, add_sum, add_c_out,
`ifdef RCA_OVF_EN
        output ovf,
`endif
        output add_a, add_b, add_c_in, sum, c_out, done0, done1, busy
    );
endinterface

// File: rtl/rca_share_arbiter.sv
// Round-robin sequencer sharing one multicycle ripple-carry adder between two requesters.
// Optional: define RCA_OVF_EN to add a registered two's-complement overflow flag (bus.ovf).
module rca_share_arbiter #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    rca_share_arbiter_if.slave  bus
);
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             grant_id;
    logic             last_grant;
    logic             win_id;
    logic             any_req;
    logic             cnt_last;
    logic             busy_c;
    logic [WIDTH-1:0] op_a_p0;
    logic [WIDTH-1:0] op_b_p0;
    logic             op_c_p0;
    logic [WIDTH-1:0] sum_p1;
    logic             c_out_p1;
    logic             done0_p1;
    logic             done1_p1;
`ifdef RCA_OVF_EN
    logic             ovf_p1;

    function automatic logic ovf_of(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction
`endif

    assign any_req  = bus.req0 | bus.req1;
    // On a tie the requester that was not served last wins; otherwise the lone requester.
    assign win_id   = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)  state_nxt = SETTLE;
            SETTLE:  if (cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        case (state)
            SETTLE, DONE: busy_c = 1'b1;
            default:      busy_c = 1'b0;
        endcase
    end

    // Stage p0: operands latched at the grant edge; stage p1: result captured after settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            op_a_p0    <= '0;
            op_b_p0    <= '0;
            op_c_p0    <= 1'b0;
            sum_p1     <= '0;
            c_out_p1   <= 1'b0;
            done0_p1   <= 1'b0;
            done1_p1   <= 1'b0;
`ifdef RCA_OVF_EN
            ovf_p1     <= 1'b0;
`endif
        end else begin
            done0_p1 <= 1'b0;
            done1_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a_p0    <= win_id ? bus.a1    : bus.a0;
                        op_b_p0    <= win_id ? bus.b1    : bus.b0;
                        op_c_p0    <= win_id ? bus.c_in1 : bus.c_in0;
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        cnt        <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt_last) begin
                        sum_p1   <= bus.add_sum;
                        c_out_p1 <= bus.add_c_out;
                        done0_p1 <= ~grant_id;
                        done1_p1 <= grant_id;
`ifdef RCA_OVF_EN
                        ovf_p1   <= ovf_of(op_a_p0, op_b_p0, bus.add_sum);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.add_a    = op_a_p0;
    assign bus.add_b    = op_b_p0;
    assign bus.add_c_in = op_c_p0;
    assign bus.sum      = sum_p1;
    assign bus.c_out    = c_out_p1;
    assign bus.done0    = done0_p1;
    assign bus.done1    = done1_p1;
    assign bus.busy     = busy_c;
`ifdef RCA_OVF_EN
    assign bus.ovf      = ovf_p1;
`endif
endmodule

// File: tb/tb_rca_share_arbiter.sv
// Scoreboard bench for rca_share_arbiter: randomized jobs from two requesters, round-robin
// reference model, directed corner cases, reset during a transaction.
`timescale 1ns/1ps
module tb_rca_share_arbiter;
    localparam int WIDTH = 64;
    localparam int S     = 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
    } op_t;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rr_last;
    exp_t exp_q[$];
    op_t  ops0[$];
    op_t  ops1[$];
    logic [WIDTH:0] adder_q = '0;

    rca_share_arbiter_if #(.WIDTH(WIDTH)) bus();

    rca_share_arbiter #(.WIDTH(WIDTH), .SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ripple adder: its result lags the inputs by a clock.
    always @(posedge clk)
        adder_q <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_c_in};
    assign bus.add_sum   = adder_q[WIDTH-1:0];
    assign bus.add_c_out = adder_q[WIDTH];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic op_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        op_t o;
        o.a = a;
        o.b = b;
        o.c = c;
        return o;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return '0;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'({$urandom, $urandom});
        endcase
    endfunction

    function automatic op_t rnd_op();
        return mk(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
    endfunction

    // Unsigned wrap-around add with carry, and signed overflow from the operand/sum signs.
    function automatic exp_t model(input logic id, input op_t op);
        exp_t           e;
        logic [WIDTH:0] full;
        full    = {1'b0, op.a} + {1'b0, op.b} + (WIDTH+1)'(op.c);
        e.id    = id;
        e.sum   = full[WIDTH-1:0];
        e.c_out = full[WIDTH];
        e.ovf   = (op.a[WIDTH-1] == op.b[WIDTH-1]) && (full[WIDTH-1] != op.a[WIDTH-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.done0 || bus.done1) begin
            chk1("done_exclusive", bus.done0 & bus.done1, 1'b0);
            chk1("done_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk1("done_id", bus.done1, e.id);
                chk("sum", bus.sum, e.sum);
                chk1("c_out", bus.c_out, e.c_out);
`ifdef RCA_OVF_EN
                chk1("ovf", bus.ovf, e.ovf);
`endif
            end
        end
    end

    // Serves everything queued in ops0/ops1; each requester holds req until its last job is done.
    task automatic run_jobs(input bit scramble);
        int   n0, n1, i0, i1, r0, r1, total, served, cyc, busy_cnt, last_done;
        logic last;
        op_t  first_op;
        n0    = ops0.size();
        n1    = ops1.size();
        total = n0 + n1;
        r0    = 0;
        r1    = 0;
        last  = rr_last;
        for (int k = 0; k < total; k++) begin
            if (r0 < n0 && (r1 >= n1 || last == 1'b1)) begin
                exp_q.push_back(model(1'b0, ops0[r0]));
                r0++;
                last = 1'b0;
            end else begin
                exp_q.push_back(model(1'b1, ops1[r1]));
                r1++;
                last = 1'b1;
            end
        end
        rr_last  = last;
        first_op = (n0 > 0) ? ops0[0] : ops1[0];
        i0 = 0;
        i1 = 0;
        bus.req0 = (n0 > 0);
        bus.req1 = (n1 > 0);
        if (n0 > 0) {bus.a0, bus.b0, bus.c_in0} = ops0[0];
        if (n1 > 0) {bus.a1, bus.b1, bus.c_in1} = ops1[0];
        rst       = 1'b0;
        served    = 0;
        cyc       = 0;
        busy_cnt  = 0;
        last_done = 0;
        while (served < total && cyc < 20 * total + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cnt++;
            if (scramble && total == 1 && cyc <= S) begin
                chk("add_a_hold", bus.add_a, first_op.a);
                chk("add_b_hold", bus.add_b, first_op.b);
                if (cyc == 1) begin
                    if (n0 > 0) begin bus.a0 = first_op.a + WIDTH'(95); bus.b0 = ~first_op.b; end
                    else        begin bus.a1 = first_op.a + WIDTH'(95); bus.b1 = ~first_op.b; end
                end
            end
            if (bus.done0 || bus.done1) begin
                if (served == 0) chk_int("first_latency", cyc, S + 1);
                else             chk_int("done_spacing", cyc - last_done, S + 2);
                last_done = cyc;
                served++;
            end
            if (bus.done0 && bus.req0) begin
                i0++;
                if (i0 < n0) {bus.a0, bus.b0, bus.c_in0} = ops0[i0];
                else         bus.req0 = 1'b0;
            end
            if (bus.done1 && bus.req1) begin
                i1++;
                if (i1 < n1) {bus.a1, bus.b1, bus.c_in1} = ops1[i1];
                else         bus.req1 = 1'b0;
            end
        end
        if (served < total) begin
            chk_int("jobs_served", served, total);
            exp_q.delete();
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        @(negedge clk);
        if (bus.busy) busy_cnt++;
        chk_int("busy_cycles", busy_cnt, total * (S + 1));
        chk1("idle_after", bus.busy, 1'b0);
        ops0.delete();
        ops1.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t hold_op;
        int  pat;
        rst       = 1'b1;
        rr_last   = 1'b1;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.a0    = '0;
        bus.b0    = '0;
        bus.c_in0 = 1'b0;
        bus.a1    = '0;
        bus.b1    = '0;
        bus.c_in1 = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_busy", bus.busy, 1'b0);
        chk("rst_sum", bus.sum, '0);
        chk1("rst_c_out", bus.c_out, 1'b0);
        chk1("rst_done0", bus.done0, 1'b0);
        chk1("rst_done1", bus.done1, 1'b0);
        chk("rst_add_a", bus.add_a, '0);
        chk("rst_add_b", bus.add_b, '0);
        chk1("rst_add_c_in", bus.add_c_in, 1'b0);

        // Single request with a0 changed after the grant: 5+7+1.
        ops0.push_back(mk(WIDTH'(5), WIDTH'(7), 1'b1));
        run_jobs(1'b1);

        ops1.push_back(mk('1, WIDTH'(1), 1'b0));
        run_jobs(1'b0);

`ifdef RCA_OVF_EN
        ops0.push_back(mk({1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0));
        run_jobs(1'b0);
        ops0.push_back(mk(WIDTH'(3), WIDTH'(4), 1'b0));
        run_jobs(1'b0);
`endif

        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            pat = int'($urandom_range(0, 2));
            if (pat != 1) ops0.push_back(rnd_op());
            if (pat != 0) ops1.push_back(rnd_op());
            run_jobs(pat != 2 && $urandom_range(0, 1) == 1);
        end

        // Reset while the adder is settling: the job is dropped, then re-served from scratch.
        @(negedge clk);
        hold_op = mk(WIDTH'(1234), WIDTH'(4321), 1'b1);
        {bus.a0, bus.b0, bus.c_in0} = hold_op;
        bus.req0 = 1'b1;
        repeat (S) @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midrst_busy", bus.busy, 1'b0);
        chk("midrst_sum", bus.sum, '0);
        chk1("midrst_done0", bus.done0, 1'b0);
        repeat (2) @(negedge clk);
        chk1("midrst_hold_done0", bus.done0, 1'b0);
        rr_last = 1'b1;
        ops0.push_back(hold_op);
        run_jobs(1'b0);

        // Both requesters contend continuously from reset release: 0,1,0,1,...
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rr_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ops0.push_back(rnd_op());
            ops1.push_back(rnd_op());
        end
        run_jobs(1'b0);

        repeat (5) @(negedge clk);
        chk_int("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_share_arbiter.md
Name: rca_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 64-bit ripple-carry adder (sixtyfour_ripple) between two requesters.
- The ripple carry chain does not close in one clock, so the adder is treated as a multicycle path.
- The block latches the granted operands and holds them stable on the adder inputs for SETTLE_CYCLES clocks.
- It then registers sum/carry and returns a one-cycle done pulse to the granted requester.

Parameters:
- WIDTH, 64: operand/sum width; must match the shared adder.
- SETTLE_CYCLES, 2: clocks the operands are held before the sum is captured; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- req0  input  1  requester 0 request; held high until done0
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- c_in0  input  1  requester 0 carry in
- req1  input  1  requester 1 request; held high until done1
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- c_in1  input  1  requester 1 carry in
- add_a  output  WIDTH  to shared adder .a
- add_b  output  WIDTH  to shared adder .b
- add_c_in  output  1  to shared adder .c_in
- add_sum  input  WIDTH  from shared adder .sum
- add_c_out  input  1  from shared adder .c_out
- sum  output  WIDTH  registered result
- c_out  output  1  registered carry out
- done0  output  1  one-cycle pulse, result for requester 0 valid
- done1  output  1  one-cycle pulse, result for requester 1 valid
- busy  output  1  high in SETTLE and DONE

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; cnt=0; last_grant=1, so requester 0 wins the first tie.
  - Operand registers, sum, c_out, done0/1 and busy are all 0.
  - A transaction in flight is dropped; no done pulse is issued.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Exactly one req high: grant it.
    - Both req high: grant the requester that is not last_grant.
    - On grant: latch a/b/c_in of the winner into operand registers, record grant_id, set last_grant=grant_id, cnt=0, go to SETTLE.
  - SETTLE:
    - add_a/add_b/add_c_in are driven only from the operand registers and are stable for the whole state.
    - When cnt==SETTLE_CYCLES-1: register sum<=add_sum and c_out<=add_c_out, go to DONE.
    - Otherwise cnt<=cnt+1.
  - DONE:
    - done[grant_id]=1 for exactly this cycle; the other done stays 0.
    - sum/c_out are valid and held until the next capture.
    - Next edge: go to IDLE. There is no grant in DONE, giving a fixed one-cycle bubble.
- Latency:
  - Grant edge is E. Capture happens at edge E+SETTLE_CYCLES. The done pulse appears in the cycle following that edge.
  - Minimum request-to-request spacing is SETTLE_CYCLES+2 clocks.
- Handshake:
  - Requester keeps req and operands stable until done. Operands are sampled only at the grant edge; later changes are ignored.
  - Requester drops req in the cycle after done.
  - If req is still high in IDLE, it is re-arbitrated as a new request; round-robin still prefers the other requester.
  - req deasserted during SETTLE does not abort the transaction; done still pulses.
- Arithmetic:
  - Unsigned WIDTH-bit add with wrap-around; carry is reported on c_out.
  - Example: all-ones + 1 gives sum=0, c_out=1.
- Outputs are registered except add_* (which come from registers) and busy (decoded from state).

Optional Feature:
- Macro RCA_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit), registered together with sum.
  - ovf = (opA[WIDTH-1]==opB[WIDTH-1]) && (add_sum[WIDTH-1]!=opA[WIDTH-1]), i.e. two's-complement overflow.
  - ovf resets to 0 and is held with sum.
- When undefined: no ovf port, and no overflow logic is generated.

Test Plan:
- Single request: req0=1, a0=5, b0=7, c_in0=1, SETTLE_CYCLES=2 → done0 pulses 2 cycles after the grant edge; sum=13, c_out=0; done1 stays 0; busy high for 3 cycles.
- Carry/wrap: req1=1, a1=64'hFFFF_FFFF_FFFF_FFFF, b1=1, c_in1=0 → sum=0, c_out=1, done1 pulses.
- Contention:
  - Setup: req0 and req1 both high from reset release.
  - Required order: requester 0 served first (done0), then requester 1 (done1).
  - Continued contention: with both held high afterwards, grants alternate 0,1,0,1.
  - Capture check: each done carries the sum of that requester's operands, as checked by a behavioural a+b+c_in model.
- Operand stability: change a0 from 5 to 100 one cycle after grant → add_a stays 5 through SETTLE, and sum reflects 5.
- Reset mid-operation: assert rst in SETTLE → busy=0, sum=0, no done pulse. After release, req0 is granted again and completes normally.
- RCA_OVF_EN build: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → ovf=1, c_out=0. Then a=3, b=4 → ovf=0.
